// File: rtl/ifu_fetch.sv
// ifu_fetch
// Instruction fetch unit and owner of the program counter. It issues word
// reads on the instruction bus (req/gnt/rvalid) and tracks up to two
// outstanding requests. Returned words are buffered with their addresses in
// a 2-entry FIFO. The FIFO head goes to the IF/ID register over a valid/ready
// handshake. A jump from EX flushes the FIFO, discards in-flight responses
// and redirects fetch.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous active-low reset
//   ibus_req_o     read request valid
//   ibus_addr_o    read address (current pc), word aligned
//   ibus_gnt_i     request accepted this cycle
//   ibus_rvalid_i  read data valid; responses return in request order
//   ibus_rdata_i   read data
//   jump_flag_i    redirect request from EX
//   jump_addr_i    redirect target; the low two bits are ignored
//   inst_valid_o   FIFO head valid
//   inst_ready_i   decode side accepts the head
//   inst_o         head instruction; NOP when empty
//   inst_addr_o    head address; 0 when empty
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [2:0]  CREDITS = 3'(DEPTH);

  // Program counter
  logic [31:0] pc_q, pc_d;

  // Tag queue: addresses of granted requests whose data has not returned yet.
  // Entry 0 is always the oldest.
  logic [31:0] tag_q [2];
  logic [31:0] tag_d [2];
  logic [1:0]  outCnt_q, outCnt_d;

  // Number of in-flight responses still to be thrown away after a jump
  logic [1:0]  dCnt_q, dCnt_d;

  // Instruction FIFO; entry 0 is the head presented to decode
  logic [31:0] fAddr_q [2];
  logic [31:0] fAddr_d [2];
  logic [31:0] fInst_q [2];
  logic [31:0] fInst_d [2];
  logic [1:0]  fCnt_q, fCnt_d;

  logic        popHead;
  logic        grantFire;
  logic        rspFire;
  logic        keepRsp;
  logic [2:0]  creditUsed;

  // Handshake decode. A slot is counted as used if it is buffered or still in
  // flight on the bus, so a request is only made when its response is
  // guaranteed a FIFO entry. The head popped this cycle already frees its slot,
  // which is what allows one instruction per cycle with ready held high.
  always_comb begin
    popHead    = (fCnt_q != 2'd0) & inst_ready_i & ~jump_flag_i;
    creditUsed = {1'b0, fCnt_q} + {1'b0, outCnt_q} - {2'b00, popHead};
    ibus_req_o = rst & ~jump_flag_i & (creditUsed < CREDITS);
    grantFire  = ibus_req_o & ibus_gnt_i;
    // A response with nothing outstanding is a bus protocol error; ignore it.
    rspFire    = ibus_rvalid_i & (outCnt_q != 2'd0);
    keepRsp    = rspFire & (dCnt_q == 2'd0) & ~jump_flag_i;
  end

  // Next-state logic. Pops are applied before pushes so that a pop, a push
  // and a grant in the same cycle all land in the right slots.
  always_comb begin
    pc_d     = pc_q;
    tag_d    = tag_q;
    outCnt_d = outCnt_q;
    dCnt_d   = dCnt_q;
    fAddr_d  = fAddr_q;
    fInst_d  = fInst_q;
    fCnt_d   = fCnt_q;

    if (jump_flag_i) begin
      pc_d = jump_addr_i & 32'hFFFF_FFFC;
    end else if (grantFire) begin
      pc_d = pc_q + 32'd4;
    end

    if (rspFire) begin
      tag_d[0] = tag_q[1];
      outCnt_d = outCnt_q - 2'd1;
    end
    if (grantFire) begin
      tag_d[outCnt_d[0]] = pc_q;
      outCnt_d           = outCnt_d + 2'd1;
    end

    // Every response still in flight at the jump belongs to the old path,
    // except the one arriving in the jump cycle itself, which is dropped here.
    if (jump_flag_i) begin
      dCnt_d = outCnt_q - {1'b0, rspFire};
    end else if (rspFire && (dCnt_q != 2'd0)) begin
      dCnt_d = dCnt_q - 2'd1;
    end

    if (jump_flag_i) begin
      fCnt_d = 2'd0;
    end else begin
      if (popHead) begin
        fAddr_d[0] = fAddr_q[1];
        fInst_d[0] = fInst_q[1];
        fCnt_d     = fCnt_q - 2'd1;
      end
      if (keepRsp) begin
        fAddr_d[fCnt_d[0]] = tag_q[0];
        fInst_d[fCnt_d[0]] = ibus_rdata_i;
        fCnt_d             = fCnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= {RESET_ADDR[31:2], 2'b00};
      tag_q    <= '{default: '0};
      outCnt_q <= 2'd0;
      dCnt_q   <= 2'd0;
      fAddr_q  <= '{default: '0};
      fInst_q  <= '{default: '0};
      fCnt_q   <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      tag_q    <= tag_d;
      outCnt_q <= outCnt_d;
      dCnt_q   <= dCnt_d;
      fAddr_q  <= fAddr_d;
      fInst_q  <= fInst_d;
      fCnt_q   <= fCnt_d;
    end
  end

  assign ibus_addr_o  = pc_q;
  assign inst_valid_o = (fCnt_q != 2'd0);
  assign inst_o       = inst_valid_o ? fInst_q[0] : NOP;
  assign inst_addr_o  = inst_valid_o ? fAddr_q[0] : 32'd0;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
// Bench for ifu_fetch. A randomized in-order memory drives the instruction
// bus. The reference model is the architectural fetch stream: after a reset
// or a jump the decode side must see consecutive words starting at the
// (aligned) target, each carrying the memory contents of its address, with
// nothing lost, repeated or stale. Every redirect pushes that stream into a
// scoreboard queue and a monitor pops it on each decode handshake.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          EXP_WINDOW = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_ADDR(RESET_ADDR),
    .DEPTH     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] busPending[$];
  logic [31:0] expReqAddr;
  int unsigned gntPct;
  int unsigned rvPct;
  int          checksDone   = 0;
  int          checksPassed = 0;
  int          handshakes   = 0;

  // Memory contents: distinct for every address so stale or misplaced data
  // cannot pass as the expected word.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksDone++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic checkBound(input string name, input int act, input int lo, input int hi);
    checksDone++;
    if (act >= lo && act <= hi) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
  endtask

  // Restart the expected fetch stream at an aligned target.
  task automatic redirectModel(input logic [31:0] tgt);
    logic [31:0] a;
    expQ.delete();
    a = tgt & 32'hFFFF_FFFC;
    expReqAddr = a;
    for (int i = 0; i < EXP_WINDOW; i++) begin
      expQ.push_back('{addr: a, inst: memData(a)});
      a = a + 32'd4;
    end
  endtask

  // Drive one cycle of stimulus shortly after the rising edge.
  task automatic applyStimulus(input logic rstV, input logic jumpV,
                               input logic [31:0] jumpA, input logic readyV);
    @(posedge clk);
    #1;
    rst          = rstV;
    jump_flag_i  = jumpV;
    jump_addr_i  = jumpA;
    inst_ready_i = readyV;
    if (!rstV) redirectModel(RESET_ADDR);
    else if (jumpV) redirectModel(jumpA);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic waitValid(input string name, input logic [31:0] expAddr);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      if (inst_valid_o) begin
        checkOutput(name, inst_addr_o, expAddr);
        return;
      end
    end
    checksDone++;
    $display("[TB] FAIL %s: inst_valid_o never rose within 30 cycles", name);
  endtask

  function automatic int unsigned pickPct();
    case ($urandom_range(2))
      0:       return 30;
      1:       return 70;
      default: return 100;
    endcase
  endfunction

  // In-order memory: may grant at random and answers the oldest granted
  // request at random, never in its grant cycle. It is reset with the DUT.
  initial begin
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        busPending.delete();
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = $urandom;
      end else begin
        ibus_gnt_i = ($urandom_range(99) < gntPct);
        if (busPending.size() > 0 && $urandom_range(99) < rvPct) begin
          ibus_rvalid_i = 1'b1;
          ibus_rdata_i  = memData(busPending[0]);
        end else begin
          ibus_rvalid_i = 1'b0;
          ibus_rdata_i  = $urandom;
        end
      end
    end
  end

  // Monitor: samples mid-cycle and scores everything that the next rising
  // edge will commit.
  initial begin
    logic        holdValid;
    logic [31:0] holdAddr;
    logic [31:0] holdInst;
    exp_t        e;
    holdValid = 1'b0;
    holdAddr  = 32'd0;
    holdInst  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("req_during_reset", 32'(ibus_req_o), 32'd0);
        holdValid = 1'b0;
      end else begin
        if (jump_flag_i) checkOutput("req_during_jump", 32'(ibus_req_o), 32'd0);
        if (ibus_req_o) begin
          checkOutput("req_addr", ibus_addr_o, expReqAddr);
          if (ibus_gnt_i) expReqAddr = expReqAddr + 32'd4;
        end
        if (ibus_rvalid_i && busPending.size() > 0) void'(busPending.pop_front());
        if (ibus_req_o && ibus_gnt_i) busPending.push_back(ibus_addr_o);
        checkBound("outstanding", busPending.size(), 0, 2);

        if (inst_valid_o && inst_ready_i && !jump_flag_i) begin
          handshakes++;
          if (expQ.size() == 0) begin
            checksDone++;
            $display("[TB] FAIL scoreboard_empty: got addr %h with nothing expected", inst_addr_o);
          end else begin
            e = expQ.pop_front();
            checkOutput("inst_addr", inst_addr_o, e.addr);
            checkOutput("inst_data", inst_o, e.inst);
          end
        end
        if (!inst_valid_o) begin
          checkOutput("empty_inst", inst_o, NOP);
          checkOutput("empty_addr", inst_addr_o, 32'd0);
        end
        if (holdValid) begin
          checkOutput("hold_valid", 32'(inst_valid_o), 32'd1);
          checkOutput("hold_addr", inst_addr_o, holdAddr);
          checkOutput("hold_inst", inst_o, holdInst);
        end
        holdValid = inst_valid_o && !inst_ready_i && !jump_flag_i;
        holdAddr  = inst_addr_o;
        holdInst  = inst_o;
      end
    end
  end

  initial begin
    int sinceRedirect;
    int r;
    logic rdy;

    rst          = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 32'd0;
    inst_ready_i = 1'b1;
    gntPct       = 100;
    rvPct        = 100;
    redirectModel(RESET_ADDR);

    // Zero-wait memory: first request, 2-cycle latency, 1/cycle throughput
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("first_req", 32'(ibus_req_o), 32'd1);
    checkOutput("first_addr", ibus_addr_o, RESET_ADDR);
    checkOutput("c0_valid", 32'(inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("c1_valid", 32'(inst_valid_o), 32'd0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput("stream_valid", 32'(inst_valid_o), 32'd1);
      checkOutput("stream_addr", inst_addr_o, 32'(4 * k));
      checkOutput("stream_req", 32'(ibus_req_o), 32'd1);
    end

    // Decode stalls for 5 cycles: FIFO fills, requests stop, head is held
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
    end
    checkOutput("stall_req", 32'(ibus_req_o), 32'd0);
    checkOutput("stall_valid", 32'(inst_valid_o), 32'd1);
    checkOutput("stall_head", inst_addr_o, expQ[0].addr);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Grant withheld for 3 cycles: request and address must hold
    gntPct = 0;
    resetDut();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      checkOutput("nognt_req", 32'(ibus_req_o), 32'd1);
      checkOutput("nognt_addr", ibus_addr_o, RESET_ADDR);
    end
    gntPct = 100;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("gnt_addr", ibus_addr_o, RESET_ADDR);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("after_gnt_addr", ibus_addr_o, RESET_ADDR + 32'd4);

    // Two requests outstanding, then jump to an unaligned target
    rvPct = 0;
    resetDut();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("two_out_req", 32'(ibus_req_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    rvPct = 100;
    waitValid("jump_first_valid", 32'h0000_0100);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Jump while a response arrives and the head is being accepted
    resetDut();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("flush_valid_j1", 32'(inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("flush_valid_j2", 32'(inst_valid_o), 32'd0);
    waitValid("flush_first_valid", 32'h0000_0200);

    // Jump with two outstanding and one of them returning in the jump cycle
    rvPct = 0;
    resetDut();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    rvPct = 100;
    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("drop_valid_j1", 32'(inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("drop_valid_j2", 32'(inst_valid_o), 32'd0);
    waitValid("drop_first_valid", 32'h0000_0300);

    // Reset pulse with the FIFO full
    resetDut();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("full_req", 32'(ibus_req_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("rst_valid", 32'(inst_valid_o), 32'd0);
    checkOutput("rst_inst", inst_o, NOP);
    checkOutput("rst_inst_addr", inst_addr_o, 32'd0);
    checkOutput("rst_req", 32'(ibus_req_o), 32'd1);
    checkOutput("rst_req_addr", ibus_addr_o, RESET_ADDR);
    waitValid("rst_restart", RESET_ADDR);

    // Reset pulse with requests outstanding
    rvPct = 0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    rvPct = 100;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("rst2_req_addr", ibus_addr_o, RESET_ADDR);
    waitValid("rst2_restart", RESET_ADDR);

    // Randomized traffic with jumps and occasional resets
    gntPct = 70;
    rvPct  = 70;
    resetDut();
    sinceRedirect = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c % 50 == 0) begin
        gntPct = pickPct();
        rvPct  = pickPct();
      end
      rdy = ($urandom_range(99) < 75);
      r   = int'($urandom_range(999));
      if (r < 5) begin
        applyStimulus(1'b0, 1'b0, 32'd0, rdy);
        sinceRedirect = 0;
      end else if (r < 35 || sinceRedirect >= 50) begin
        applyStimulus(1'b1, 1'b1, $urandom, rdy);
        sinceRedirect = 0;
      end else begin
        applyStimulus(1'b1, 1'b0, $urandom, rdy);
        sinceRedirect++;
      end
    end
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkBound("handshake_total", handshakes, 300, 100000);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
